mul_div_unit: RTL and testbench

//   Iterative multiply/divide unit with architectural HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).

---
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// Optional build macro MDU_EARLY_TERM_EN: multiplies leave RUN once no multiplier bits remain.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic               div_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic               run_exit;

    assign busy = (state != S_IDLE);

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        div_zero  = op[1] & (b == '0);
    end

    // For divides acc is {remainder, dividend/quotient}; each step shifts one
    // dividend bit into the remainder and keeps the trial difference if it is non-negative.
    always_comb begin
        mul_next = acc + (mplier[0] ? mcand : '0);
        trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mcand[WIDTH-1:0]};
        if (trial[WIDTH])
            div_next = {acc[2*WIDTH-2:0], 1'b0};
        else
            div_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_fixed = neg_main ? -acc : acc;
        quo_fixed  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fixed  = neg_rem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

`ifdef MDU_EARLY_TERM_EN
    assign run_exit = (cnt == LAST_STEP) || (!is_div && (mplier[WIDTH-1:1] == '0));
`else
    assign run_exit = (cnt == LAST_STEP);
`endif

    // A zero divisor latches the raw dividend with sign fixing disabled, so the
    // restoring loop naturally yields remainder=a and an all-ones quotient.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_hi)
                        hi <= wd;
                    if (wr_lo)
                        lo <= wd;
                    if (start) begin
                        is_div   <= op[1];
                        neg_main <= (a_neg ^ b_neg) & ~div_zero;
                        neg_rem  <= op[1] & a_neg & ~div_zero;
                        cnt      <= '0;
                        mplier   <= b_mag;
                        if (op[1]) begin
                            mcand <= {{WIDTH{1'b0}}, b_mag};
                            acc   <= {{WIDTH{1'b0}}, (div_zero ? a : a_mag)};
                        end else begin
                            mcand <= {{WIDTH{1'b0}}, a_mag};
                            acc   <= '0;
                        end
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        acc <= div_next;
                    end else begin
                        acc    <= mul_next;
                        mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                        mplier <= mplier >> 1;
                    end
                    if (run_exit)
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= rem_fixed;
                        lo <= quo_fixed;
                    end else begin
                        {hi, lo} <= prod_fixed;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the driver queues expected HI/LO and done time,
// an independent monitor pops and compares on every done pulse.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wd;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
        int           id;
    } exp_t;

    exp_t         exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           next_id = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Plain-arithmetic reference: 64-bit products and C-style truncating division.
    function automatic void refModel(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint       sx;
        longint       sy;
        longint       q;
        longint       r;
        logic [63:0]  p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin
                p = 64'(sx * sy);
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b01: begin
                p = {32'b0, x} * {32'b0, y};
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (y == '0) begin
                    rh = x;
                    rl = '1;
                end else if (o == 2'b10) begin
                    q = sx / sy;
                    r = sx % sy;
                    rh = r[31:0];
                    rl = q[31:0];
                end else begin
                    rh = x % y;
                    rl = x / y;
                end
            end
        endcase
    endfunction

    function automatic int refLatency(input logic [1:0] o, input logic [W-1:0] y);
        int steps = W;
`ifdef MDU_EARLY_TERM_EN
        logic [W-1:0] m;
        if (!o[1]) begin
            m = (!o[0] && y[W-1]) ? -y : y;
            steps = 1;
            for (int i = 0; i < W; i++)
                if (m[i]) steps = i + 1;
        end
`endif
        return steps + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one op (optionally with a same-edge MTHI/MTLO) and queues its expected result.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic wh, input logic wl, input logic [W-1:0] v);
        exp_t         e;
        logic [W-1:0] rh;
        logic [W-1:0] rl;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        wr_hi = wh; wr_lo = wl; wd = v;
        refModel(o, x, y, rh, rl);
        e.hi = rh;
        e.lo = rl;
        e.due = cyc + 1 + refLatency(o, y);
        e.id = next_id;
        next_id++;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        a = $urandom; b = $urandom;
        if (wh) model_hi = v;
        if (wl) model_lo = v;
        checkOutput($sformatf("op%0d busy", e.id), W'(busy), W'(1));
        checkOutput($sformatf("op%0d hi at accept", e.id), hi, model_hi);
        checkOutput($sformatf("op%0d lo at accept", e.id), lo, model_lo);
        model_hi = rh;
        model_lo = rl;
    endtask

    task automatic waitDone();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL done timeout: got no done after %0d cycles, expected done", n);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic writeRegs(input logic wh, input logic wl, input logic [W-1:0] v);
        @(negedge clk);
        wr_hi = wh; wr_lo = wl; wd = v;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        if (wh) model_hi = v;
        if (wl) model_lo = v;
        checkOutput("mt hi", hi, model_hi);
        checkOutput("mt lo", lo, model_lo);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL spurious done: got done=1, expected no pending op");
            end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("op%0d hi", e.id), hi, e.hi);
                checkOutput($sformatf("op%0d lo", e.id), lo, e.lo);
                checkOutput($sformatf("op%0d done cycle", e.id), W'(cyc), W'(e.due));
                checkOutput($sformatf("op%0d busy at done", e.id), W'(busy), W'(0));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wd = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset hi", hi, '0);
        checkOutput("reset lo", lo, '0);
        checkOutput("reset busy", W'(busy), W'(0));
        checkOutput("reset done", W'(done), W'(0));
        reset = 1'b0;

        applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, '0); waitDone();
        applyStimulus(2'b00, -32'sd3, 32'd7, 1'b0, 1'b0, '0);           waitDone();
        applyStimulus(2'b10, -32'sd7, 32'd2, 1'b0, 1'b0, '0);           waitDone();
        applyStimulus(2'b11, 32'd5, 32'd0, 1'b0, 1'b0, '0);             waitDone();
        applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, '0); waitDone();
        applyStimulus(2'b10, -32'sd9, 32'd0, 1'b0, 1'b0, '0);           waitDone();
        applyStimulus(2'b10, 32'd7, -32'sd2, 1'b0, 1'b0, '0);           waitDone();
        applyStimulus(2'b00, 32'h80000000, 32'h80000000, 1'b0, 1'b0, '0); waitDone();
        applyStimulus(2'b01, 32'd5, 32'd3, 1'b0, 1'b0, '0);             waitDone();

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            applyStimulus(ro, ra, rb, 1'b0, 1'b0, '0);
            waitDone();
        end

        writeRegs(1'b1, 1'b0, 32'hCAFE0001);
        writeRegs(1'b0, 1'b1, 32'hBEEF0002);
        writeRegs(1'b1, 1'b1, 32'h0BAD0003);

        // Same-edge MTHI/MTLO lands first, then the product overwrites both.
        applyStimulus(2'b01, 32'd6, 32'd7, 1'b1, 1'b1, 32'h00005555);
        waitDone();

        // A start and MTHI issued mid-operation must both be dropped.
        applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, '0);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b00; a = $urandom; b = $urandom;
        wr_hi = 1'b1; wd = 32'h00001234;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0;
        waitDone();
        repeat (40) @(negedge clk);
        checkOutput("ignored hi", hi, model_hi);
        checkOutput("ignored lo", lo, model_lo);

        applyStimulus(2'b00, 32'd12345, -32'sd678, 1'b0, 1'b0, '0);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        void'(exp_q.pop_back());
        model_hi = '0;
        model_lo = '0;
        checkOutput("abort busy", W'(busy), W'(0));
        checkOutput("abort done", W'(done), W'(0));
        checkOutput("abort hi", hi, '0);
        checkOutput("abort lo", lo, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("post-abort hi", hi, '0);
        checkOutput("post-abort lo", lo, '0);
        checkOutput("post-abort busy", W'(busy), W'(0));
        checkOutput("pending ops", W'(exp_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
